mem_write_monitor: RTL
======================

// Module: mem_write_monitor
// PURPOSE
//  Synthesizable store-bus checker that sits directly downstream of the multicycle ARM top.
//  Consumes the top's data-side bus (MemWrite, Adr, WriteData) every cycle and decides
//  pass/fail on-chip, replacing ad-hoc testbench checks.
//  Also counts stores and times out a hung program. Results are sticky for waveform and FPGA LED readout.
// PARAMETERS
//  PASS_ADR   32'd100  store address that ends the run
//  PASS_DATA  32'd7    data required at PASS_ADR for pass
//  ALLOW_ADR  32'd96   intermediate store address tolerated without verdict
//  TIMEOUT    1000     cycles after reset release before timeout fail (>=2)
//  CNT_W      16       width of cycle counter (2**CNT_W > TIMEOUT)
// PORTS
//  clk          in   1      system clock, all state on posedge
//  reset        in   1      asynchronous, active-high; clears all state
//  MemWrite     in   1      store strobe from top, qualifies Adr/WriteData
//  Adr          in   32     memory address from top
//  WriteData    in   32     store data from top
//  done         out  1      verdict reached (PASS or FAIL)
//  pass         out  1      run succeeded
//  fail         out  1      run failed
//  fail_code    out  2      00 none, 01 illegal addr, 10 bad data at PASS_ADR, 11 timeout
//  store_count  out  8      accepted stores, saturates at 255
//  cycle_count  out  CNT_W  cycles spent in RUN, saturates at all-ones
//  last_adr     out  32     Adr of most recent store seen in RUN
//  last_data    out  32     WriteData of most recent store seen in RUN
// BEHAVIOUR
//  - Reset (async assert): state=IDLE; all outputs 0. Deassertion is taken at the next posedge.
//  - FSM states: IDLE, RUN, PASS, FAIL.
//    - IDLE -> RUN on the first posedge with reset low; no store is evaluated in IDLE.
//    - RUN, MemWrite=1, Adr==PASS_ADR, WriteData==PASS_DATA -> PASS.
//    - RUN, MemWrite=1, Adr==PASS_ADR, data mismatch -> FAIL, code 10.
//    - RUN, MemWrite=1, Adr==ALLOW_ADR -> stay RUN.
//    - RUN, MemWrite=1, any other Adr -> FAIL, code 01.
//    - RUN, cycle_count==TIMEOUT-1 with no store verdict that cycle -> FAIL, code 11.
//    - PASS/FAIL are terminal until reset. Inputs are ignored there and counters freeze.
//  - Every RUN cycle with MemWrite=1 (incl. the deciding one) does the following:
//    store_count++ (saturating); last_adr/last_data <= Adr/WriteData.
//  - cycle_count increments on every RUN cycle, starting at 0 on the first RUN cycle.
//  - Latency: the verdict is visible one posedge after the sampled store.
//    - done=pass|fail is registered together with the verdict.
//    - pass and fail are never both 1.
//  - Simultaneous events: a store verdict on the timeout cycle wins over the timeout.
//  - MemWrite held high several cycles: each cycle is a separate store. The first decisive one ends the run.
//  - Reset mid-run or after a verdict: immediate return to IDLE, all outputs 0.
//  - Comparisons are full 32-bit equality. No byte enables; Adr is not word-aligned checked.
// TESTING
//  1. Reset 22ns, then store (96,3) then (100,7) -> pass=1, done=1, fail_code=00, store_count=2,
//     last_adr=100, last_data=7.
//  2. Store (100,6) -> fail=1, fail_code=10, last_data=6; a later (100,7) leaves the verdict unchanged.
//  3. Store (104,7) -> fail=1, fail_code=01 one posedge after the strobe.
//  4. No stores, TIMEOUT=20 -> fail_code=11 with cycle_count=19 and store_count=0.
//     Variant: store (100,7) exactly on cycle 19 -> pass.
//  5. MemWrite high at the same posedge reset is released -> ignored (IDLE).
//     Store (96,x) 300 times -> store_count=255, still RUN.
//  6. Assert reset asynchronously mid-RUN, between clock edges -> all outputs 0 immediately;
//     after release the run restarts and scenario 1 passes again.

Source files
------------

// File: rtl/mem_write_monitor.sv
// Store-bus checker for the multicycle ARM top: watches MemWrite/Adr/WriteData,
// latches a sticky PASS/FAIL verdict, counts stores and cycles, and times out a hung run.
module mem_write_monitor #(
  parameter logic [31:0] PASS_ADR  = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter logic [31:0] ALLOW_ADR = 32'd96,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      Adr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [7:0]       store_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      last_adr,
  output logic [31:0]      last_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_BADDATA = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [7:0]       store_count_q, store_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [31:0]      last_adr_q, last_adr_d;
  logic [31:0]      last_data_q, last_data_d;

  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    fail_code_d   = fail_code_q;
    store_count_d = store_count_q;
    cycle_count_d = cycle_count_q;
    last_adr_d    = last_adr_q;
    last_data_d   = last_data_q;

    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (MemWrite) begin
          if (store_count_q != 8'hFF) store_count_d = store_count_q + 8'd1;
          last_adr_d  = Adr;
          last_data_d = WriteData;
        end
        // Store verdicts take priority over the timeout; an ALLOW_ADR store is not a verdict.
        if (MemWrite && Adr == PASS_ADR) begin
          done_d = 1'b1;
          if (WriteData == PASS_DATA) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d     = S_FAIL;
            fail_d      = 1'b1;
            fail_code_d = CODE_BADDATA;
          end
        end else if (MemWrite && Adr != ALLOW_ADR) begin
          state_d     = S_FAIL;
          done_d      = 1'b1;
          fail_d      = 1'b1;
          fail_code_d = CODE_ILLEGAL;
        end else if (cycle_count_q == TIMEOUT_LAST) begin
          state_d     = S_FAIL;
          done_d      = 1'b1;
          fail_d      = 1'b1;
          fail_code_d = CODE_TIMEOUT;
        end else if (cycle_count_q != {CNT_W{1'b1}}) begin
          // The counter holds the index of the current RUN cycle, so it freezes on the deciding one.
          cycle_count_d = cycle_count_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_code_q   <= CODE_NONE;
      store_count_q <= 8'd0;
      cycle_count_q <= '0;
      last_adr_q    <= 32'd0;
      last_data_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      fail_code_q   <= fail_code_d;
      store_count_q <= store_count_d;
      cycle_count_q <= cycle_count_d;
      last_adr_q    <= last_adr_d;
      last_data_q   <= last_data_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = fail_code_q;
  assign store_count = store_count_q;
  assign cycle_count = cycle_count_q;
  assign last_adr    = last_adr_q;
  assign last_data   = last_data_q;

endmodule
